// File: rtl/comp_mult_pkg.sv
// Shared state encoding and width helpers for the complex-multiplier arbiter.
package comp_mult_pkg;
  localparam int DWIDTH_DEF = 8;
  localparam int OP_W       = 4*DWIDTH_DEF;
  localparam int RES_W      = 4*(DWIDTH_DEF+1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int op_w(input int dw);
    return 4*dw;
  endfunction

  function automatic int res_w(input int dw);
    return 4*(dw+1);
  endfunction
endpackage

// File: rtl/comp_mult_arb_if.sv
// Requester, response and multiplier handshakes of comp_mult_arb; slave is the arbiter side.
interface comp_mult_arb_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = comp_mult_pkg::DWIDTH_DEF
);
  import comp_mult_pkg::*;
  localparam int OPW  = op_w(DWIDTH);
  localparam int RESW = res_w(DWIDTH);

  logic [NREQ-1:0]      req_val;
  logic [NREQ-1:0]      req_rdy;
  logic [NREQ*OPW-1:0]  req_data;
  logic [NREQ-1:0]      rsp_val;
  logic [NREQ-1:0]      rsp_rdy;
  logic [RESW-1:0]      rsp_data;
  logic                 rsp_err;
  logic                 mop_val;
  logic                 mop_rdy;
  logic [OPW-1:0]       mop_data;
  logic                 mres_val;
  logic                 mres_rdy;
  logic [RESW-1:0]      mres_data;

  modport master (
    output req_val, req_data, rsp_rdy, mop_rdy, mres_val, mres_data,
    input  req_rdy, rsp_val, rsp_data, rsp_err, mop_val, mop_data, mres_rdy
  );

  modport slave (
    input  req_val, req_data, rsp_rdy, mop_rdy, mres_val, mres_data,
    output req_rdy, rsp_val, rsp_data, rsp_err, mop_val, mop_data, mres_rdy
  );
endinterface

// File: rtl/comp_mult_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module comp_mult_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         gnt_oh,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);
  localparam int IW = $clog2(NREQ);

  always_comb begin
    int idx;
    logic [IW-1:0] ix;
    idx     = 0;
    ix      = '0;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      ix = IW'(idx);
      if (!any && req[ix]) begin
        any         = 1'b1;
        gnt_oh[ix]  = 1'b1;
        gnt_idx     = ix;
      end
    end
  end
endmodule

// File: rtl/comp_mult_arb.sv
// Round-robin arbiter sharing one complex multiplier among NREQ requesters.
// Define COMP_MULT_ARB_TIMEOUT_EN to build in the ISSUE/WAIT watchdog (TMO_CYCLES).
module comp_mult_arb
  import comp_mult_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int NREQ       = 4,
  parameter int TMO_CYCLES = 64
) (
  input  logic            clk,
  input  logic            sw_rst,
  comp_mult_arb_if.slave  bus
);
  localparam int OPW  = op_w(DWIDTH);
  localparam int RESW = res_w(DWIDTH);
  localparam int IW   = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [RESW-1:0] res_q, res_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            tmo_hit;

  comp_mult_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req_val),
    .last    (last_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

`ifdef COMP_MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES+1);
  logic [TW-1:0] tmr_q, tmr_d;

  // Loaded on the grant so the budget covers ISSUE and WAIT together.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == ST_IDLE && pick_any)
      tmr_d = TW'(TMO_CYCLES-1);
    else if ((state_q == ST_ISSUE || state_q == ST_WAIT) && tmr_q != '0)
      tmr_d = tmr_q - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (sw_rst) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign tmo_hit = (tmr_q == '0);
`else
  // TMO_CYCLES only matters when the watchdog is built in.
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    res_d        = res_q;
    err_d        = err_q;
    bus.req_rdy  = '0;
    bus.rsp_val  = '0;
    bus.mop_val  = 1'b0;
    bus.mres_rdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_rdy  = pick_oh;
        bus.mres_rdy = 1'b1;
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = ST_ISSUE;
          for (int i = 0; i < NREQ; i++)
            if (pick_oh[i]) op_d = bus.req_data[i*OPW +: OPW];
        end
      end
      ST_ISSUE: begin
        bus.mop_val = 1'b1;
        if (bus.mop_rdy) begin
          state_d = ST_WAIT;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        bus.mres_rdy = 1'b1;
        if (bus.mres_val) begin
          state_d = ST_RESP;
          res_d   = bus.mres_data;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        bus.rsp_val[gnt_q] = 1'b1;
        if (bus.rsp_rdy[gnt_q]) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ-1);
      gnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.mop_data = op_q;
  assign bus.rsp_data = res_q;
  assign bus.rsp_err  = err_q;
endmodule

// File: tb/tb_comp_mult_arb.sv
// Self-checking bench for comp_mult_arb: transaction-level model plus directed and random stimulus.
module tb_comp_mult_arb;
  localparam int DW   = 8;
  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int OPW  = 4*DW;
  localparam int RESW = 4*(DW+1);
  localparam int CW   = RESW/2;

  logic clk = 1'b0;
  logic sw_rst;
  always #5 clk = ~clk;

  comp_mult_arb_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

  comp_mult_arb #(.DWIDTH(DW), .NREQ(NREQ), .TMO_CYCLES(TMO)) dut (
    .clk    (clk),
    .sw_rst (sw_rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // staged stimulus, applied just after each rising edge
  logic [NREQ-1:0] s_req_val, s_rsp_rdy;
  logic [OPW-1:0]  s_data [NREQ];
  logic            s_rst, s_mop_en;
  int              s_lat;

  // bench-side multiplier
  bit              mul_busy;
  int              mul_cnt;
  logic [RESW-1:0] mul_res;

  // transaction-level model of the arbiter
  int              m_last, m_gnt, m_tmr;
  bit              m_busy, m_sent, m_back, m_err;
  logic [OPW-1:0]  m_op;
  logic [RESW-1:0] m_rsp;

  int grants[$];

  function automatic logic [RESW-1:0] cmul(input logic [OPW-1:0] op);
    int x1, y1, x2, y2, xr, yr;
    x1 = int'($signed(op[4*DW-1 -: DW]));
    y1 = int'($signed(op[3*DW-1 -: DW]));
    x2 = int'($signed(op[2*DW-1 -: DW]));
    y2 = int'($signed(op[DW-1 -: DW]));
    xr = x1*x2 - y1*y2;
    yr = x1*y2 + y1*x2;
    return {CW'(xr), CW'(yr)};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last+k)%NREQ]) return (last+k)%NREQ;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = NREQ-1;
    m_gnt  = 0;
    m_tmr  = 0;
    m_busy = 0;
    m_sent = 0;
    m_back = 0;
    m_err  = 0;
    m_op   = '0;
    m_rsp  = '0;
  endtask

  // Called on the falling edge: compare DUT against model, then advance both environment and model.
  task automatic model_cycle();
    int p;
    bit tmo, e_mop_val, e_mres_rdy, mop_fire, mres_fire;
    logic [NREQ-1:0] e_req_rdy, e_rsp_val;
    p = rr_pick(bus.req_val, m_last);
    e_req_rdy = '0;
    if (!m_busy && p >= 0) e_req_rdy[p] = 1'b1;
    e_rsp_val = '0;
    if (m_busy && m_back) e_rsp_val[m_gnt] = 1'b1;
    e_mop_val  = m_busy && !m_sent;
    e_mres_rdy = !m_busy || (m_sent && !m_back);

    chk("req_rdy", bus.req_rdy, e_req_rdy);
    chk("rsp_val", bus.rsp_val, e_rsp_val);
    chk("mop_val", bus.mop_val, e_mop_val);
    chk("mres_rdy", bus.mres_rdy, e_mres_rdy);
    chk("rsp_data", bus.rsp_data, m_rsp);
    if (e_mop_val) chk("mop_data", bus.mop_data, m_op);
    if (m_busy && m_back) chk("rsp_err", bus.rsp_err, m_err);

    mop_fire  = e_mop_val && bus.mop_rdy;
    mres_fire = bus.mres_val && e_mres_rdy;

    if (sw_rst) mul_busy = 0;
    else if (mop_fire) begin
      mul_busy = 1;
      mul_cnt  = s_lat;
      mul_res  = cmul(bus.mop_data);
    end else if (mres_fire) mul_busy = 0;
    else if (mul_busy && mul_cnt > 0) mul_cnt--;

    tmo = 0;
    if (sw_rst) model_reset();
    else if (!m_busy) begin
      if (p >= 0) begin
        m_busy = 1;
        m_gnt  = p;
        m_op   = bus.req_data[p*OPW +: OPW];
        m_sent = 0;
        m_back = 0;
        m_tmr  = 0;
      end
    end else if (!m_back) begin
      if (!m_sent && mop_fire) m_sent = 1;
      else if (m_sent && mres_fire) begin
        m_back = 1;
        m_rsp  = cmul(m_op);
        m_err  = 0;
      end else begin
`ifdef COMP_MULT_ARB_TIMEOUT_EN
        if (m_tmr >= TMO-1) begin
          m_sent = 1;
          m_back = 1;
          m_rsp  = '0;
          m_err  = 1;
          tmo    = 1;
        end
`endif
      end
      m_tmr++;
      if (tmo) mul_busy = 0;
    end else if (bus.rsp_rdy[m_gnt]) begin
      m_busy = 0;
      m_last = m_gnt;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sw_rst        = s_rst;
    bus.req_val   = s_req_val;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*OPW +: OPW] = s_data[i];
    bus.rsp_rdy   = s_rsp_rdy;
    bus.mop_rdy   = s_mop_en && !mul_busy;
    bus.mres_val  = mul_busy && (mul_cnt == 0);
    bus.mres_data = mul_res;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.rsp_val == '0 && n < max);
    if (bus.rsp_val == '0) begin
      checks++;
      failures++;
      $display("FAIL wait_rsp: no rsp_val within %0d cycles", max);
    end
  endtask

  task automatic collect(input int n, input int max);
    int c;
    c = 0;
    grants.delete();
    while (grants.size() < n && c < max) begin
      step();
      c++;
      for (int i = 0; i < NREQ; i++) if (bus.req_rdy[i]) grants.push_back(i);
    end
    if (grants.size() < n) begin
      checks++;
      failures++;
      $display("FAIL collect: got %0d grants expected %0d", grants.size(), n);
    end
  endtask

  initial begin
    int exp2[5];
    int exp3[2];
    int n;
    exp2 = '{0, 1, 2, 3, 0};
    exp3 = '{3, 0};
    sw_rst = 1'b1;
    bus.req_val = '0; bus.req_data = '0; bus.rsp_rdy = '0;
    bus.mop_rdy = 1'b0; bus.mres_val = 1'b0; bus.mres_data = '0;
    s_req_val = '0; s_rsp_rdy = '1; s_rst = 1'b1; s_mop_en = 1'b1; s_lat = 0;
    for (int i = 0; i < NREQ; i++) s_data[i] = OPW'(32'h11223344 * (i+1));
    mul_busy = 0; mul_cnt = 0; mul_res = '0;
    model_reset();

    // 1: single transaction (3+4j)(1+2j)
    do_reset();
    chk("rst_mop_val", bus.mop_val, 1'b0);
    chk("rst_rsp_val", bus.rsp_val, 4'b0000);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    s_data[0] = 32'h03040102;
    s_req_val = 4'b0001;
    step();
    chk("t1_req_rdy", bus.req_rdy, 4'b0001);
    s_req_val = '0;
    step();
    chk("t1_mop_val", bus.mop_val, 1'b1);
    chk("t1_mop_data", bus.mop_data, 32'h03040102);
    wait_rsp(20);
    chk("t1_rsp_val", bus.rsp_val, 4'b0001);
    chk("t1_rsp_data", bus.rsp_data, {18'h3FFFB, 18'h0000A});
    step();

    // 2: all requesting, round-robin from reset
    do_reset();
    s_req_val = '1;
    collect(5, 60);
    for (int i = 0; i < grants.size() && i < 5; i++) chk("t2_grant", grants[i], exp2[i]);

    // 3: last=1 with requesters 3 and 0 pending
    s_req_val = '0;
    do_reset();
    s_req_val = 4'b0010;
    collect(1, 10);
    s_req_val = '0;
    wait_rsp(20);
    s_req_val = 4'b1001;
    collect(2, 40);
    for (int i = 0; i < grants.size() && i < 2; i++) chk("t3_grant", grants[i], exp3[i]);

    // 4: response back-pressure, other rsp_rdy bits ignored
    s_req_val = '0;
    do_reset();
    s_req_val = 4'b0001;
    s_rsp_rdy = 4'b1110;
    s_lat = 2;
    step();
    s_req_val = '1;
    wait_rsp(20);
    for (int i = 0; i < 10; i++) begin
      chk("t4_rsp_val", bus.rsp_val, 4'b0001);
      chk("t4_rsp_data", bus.rsp_data, {18'h3FFFB, 18'h0000A});
      chk("t4_req_rdy", bus.req_rdy, 4'b0000);
      chk("t4_mres_rdy", bus.mres_rdy, 1'b0);
      step();
    end
    s_rsp_rdy = 4'b0001;
    s_req_val = '0;
    step();
    s_rsp_rdy = '1;
    step();

    // 5: reset while waiting for the multiplier
    do_reset();
    s_req_val = 4'b0001;
    s_lat = 8;
    step();
    s_req_val = '0;
    step();
    step();
    chk("t5_in_wait", bus.mres_rdy, 1'b1);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    s_req_val = '1;
    s_lat = 0;
    step();
    chk("t5_mop_val", bus.mop_val, 1'b0);
    chk("t5_rsp_val", bus.rsp_val, 4'b0000);
    chk("t5_req_rdy", bus.req_rdy, 4'b0001);
    s_req_val = '0;
    wait_rsp(20);
    step();

`ifdef COMP_MULT_ARB_TIMEOUT_EN
    // 6: multiplier never accepts
    do_reset();
    s_req_val = 4'b0001;
    s_mop_en = 1'b0;
    step();
    s_req_val = '0;
    step();
    n = 0;
    while (bus.rsp_val == '0 && n < 40) begin
      step();
      n++;
    end
    chk("t6_tmo_cycles", n, 16);
    chk("t6_rsp_err", bus.rsp_err, 1'b1);
    chk("t6_rsp_data", bus.rsp_data, '0);
    s_mop_en = 1'b1;
    step();
`else
    n = 0;
`endif

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      s_req_val = NREQ'($urandom);
      s_rsp_rdy = NREQ'($urandom);
      s_mop_en  = ($urandom_range(0, 3) != 0);
      s_lat     = $urandom_range(0, 3);
      s_rst     = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) s_data[i] = OPW'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
